// File: rtl/bus_rx_sink_pkg.sv
// Shared bus definitions for the device-bus receive path: ID field layout,
// broadcast ID, destination extraction and the saturating counter step.
package bus_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  // Widest bus word get_dest can take; narrower words are zero-extended.
  localparam int MAX_W = 64;

  function automatic logic [ID_W-1:0] get_dest(input logic [MAX_W-1:0] word,
                                               input int unsigned w);
    return word[w-1 -: ID_W];
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Circular-buffer FIFO with first-word-fall-through read; full/pndng are
// decoded from the registered occupancy only.
module rx_fifo #(
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_i,
  input  logic [width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [width-1:0]         rdata_o,
  output logic                     pndng_o,
  output logic                     full_o,
  output logic [$clog2(depth):0]   count_o
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_rd, do_wr;

  assign pndng_o = (count_q != '0);
  assign full_o  = (count_q == CW'(depth));
  assign count_o = count_q;
  // A pop on an empty FIFO is ignored; a pop frees the slot a full-FIFO write needs.
  assign do_rd   = pop_i && pndng_o;
  assign do_wr   = wr_i && (!full_o || do_rd);
  assign rdata_o = pndng_o ? mem_q[rd_q] : '0;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (do_rd) rd_d = rd_q + AW'(1);
    if (do_wr) wr_d = wr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/bus_rx_sink.sv
// Bus receive sink: captures every pushed word, filters on destination ID and
// buffers matches in rx_fifo. Define BUS_RX_BROADCAST_EN to also accept ID 8'hFF.
module bus_rx_sink
  import bus_pkg::*;
#(
  parameter int width   = 16,
  parameter int depth   = 8,
  parameter int devices = 4,
  parameter int id      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [width-1:0]       D_push,
  input  logic                   pop,
  output logic [width-1:0]       D_pop,
  output logic                   pndng,
  output logic                   full,
  output logic [$clog2(depth):0] count,
  output logic [7:0]             rx_cnt,
  output logic [7:0]             drop_cnt,
  output logic [7:0]             ovf_cnt
);

  // id must already be below devices; the modulo only clamps a misconfiguration.
  localparam logic [ID_W-1:0] MY_ID = ID_W'(id % devices);

  logic [width-1:0] in_q, in_d;
  logic             in_v_q, in_v_d;
  logic [ID_W-1:0]  dest;
  logic             hit, accept, ovf, wr;
  logic [7:0]       rx_q, rx_d, drop_q, drop_d, ovf_q, ovf_d;

  assign in_v_d = push;
  assign in_d   = push ? D_push : in_q;
  assign dest   = get_dest(MAX_W'(in_q), width);

`ifdef BUS_RX_BROADCAST_EN
  assign hit = (dest == MY_ID) || (dest == BCAST_ID);
`else
  assign hit = (dest == MY_ID);
`endif

  assign accept = in_v_q && hit;
  assign ovf    = accept && full && !pop;
  // rx_cnt counts words that actually reach the FIFO; overflow losses go to ovf_cnt.
  assign wr     = accept && !ovf;

  always_comb begin
    rx_d   = rx_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (wr)               rx_d   = sat_inc(rx_q);
    if (in_v_q && !hit)   drop_d = sat_inc(drop_q);
    if (ovf)              ovf_d  = sat_inc(ovf_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q   <= '0;
      in_v_q <= 1'b0;
      rx_q   <= '0;
      drop_q <= '0;
      ovf_q  <= '0;
    end else begin
      in_q   <= in_d;
      in_v_q <= in_v_d;
      rx_q   <= rx_d;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  assign rx_cnt   = rx_q;
  assign drop_cnt = drop_q;
  assign ovf_cnt  = ovf_q;

  rx_fifo #(
    .width (width),
    .depth (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_i    (wr),
    .wdata_i (in_q),
    .pop_i   (pop),
    .rdata_o (D_pop),
    .pndng_o (pndng),
    .full_o  (full),
    .count_o (count)
  );

endmodule

// File: tb/tb_bus_rx_sink.sv
// Bench for bus_rx_sink (id=2, width 16, depth 8): directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_bus_rx_sink;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int DEV   = 4;
  localparam int ID    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          push;
  logic [W-1:0]  d_push;
  logic          pop;
  logic [W-1:0]  d_pop;
  logic          pndng, full;
  logic [CW-1:0] count;
  logic [7:0]    rx_cnt, drop_cnt, ovf_cnt;

  always #5 clk = ~clk;

  bus_rx_sink #(.width(W), .depth(DEPTH), .devices(DEV), .id(ID)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .D_push   (d_push),
    .pop      (pop),
    .D_pop    (d_pop),
    .pndng    (pndng),
    .full     (full),
    .count    (count),
    .rx_cnt   (rx_cnt),
    .drop_cnt (drop_cnt),
    .ovf_cnt  (ovf_cnt)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  bit           pend_v;
  logic [W-1:0] pend_w;
  int           m_rx, m_drop, m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic bit accepts(input logic [W-1:0] w);
    logic [7:0] dst;
    dst = w[W-1:W-8];
    if (int'(dst) == ID) return 1'b1;
`ifdef BUS_RX_BROADCAST_EN
    if (dst == 8'hFF) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_v = 1'b0;
    pend_w = '0;
    m_rx = 0; m_drop = 0; m_ovf = 0;
  endtask

  // One rising edge: the word captured last cycle is decided now, then this
  // cycle's push is captured for the next edge.
  task automatic model_edge(input bit p, input logic [W-1:0] d, input bit pp);
    bit pop_eff, room;
    pop_eff = pp && (exp_q.size() > 0);
    room    = (exp_q.size() < DEPTH) || pop_eff;
    if (pop_eff) void'(exp_q.pop_front());
    if (pend_v) begin
      if (accepts(pend_w)) begin
        if (room) begin
          exp_q.push_back(pend_w);
          m_rx = sat(m_rx);
        end else m_ovf = sat(m_ovf);
      end else m_drop = sat(m_drop);
    end
    pend_v = p;
    pend_w = d;
  endtask

  task automatic compare_all(input string ph);
    logic [W-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check({ph, ".count"}, 32'(count), 32'(exp_q.size()));
    check({ph, ".pndng"}, 32'(pndng), 32'(exp_q.size() > 0));
    check({ph, ".full"},  32'(full),  32'(exp_q.size() == DEPTH));
    check({ph, ".d_pop"}, 32'(d_pop), 32'(head));
    check({ph, ".rx"},    32'(rx_cnt),   32'(m_rx));
    check({ph, ".drop"},  32'(drop_cnt), 32'(m_drop));
    check({ph, ".ovf"},   32'(ovf_cnt),  32'(m_ovf));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit p, input logic [W-1:0] d, input bit pp, input string ph);
    push = p; d_push = d; pop = pp;
    @(posedge clk);
    model_edge(p, d, pp);
    @(negedge clk);
    compare_all(ph);
  endtask

  task automatic idle(input int n, input string ph);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, ph);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base_rx, base_drop;
    logic [W-1:0] w;
    bit p, pp;
    int pop_pct;

    rst_n = 1'b1; push = 1'b0; d_push = '0; pop = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // directed receive
    step(1'b1, 16'h0234, 1'b0, "rx");
    step(1'b0, '0, 1'b0, "rx");
    check("rx.pndng_const", 32'(pndng), 32'd1);
    check("rx.dpop_const",  32'(d_pop), 32'h0234);
    check("rx.cnt_const",   32'(rx_cnt), 32'd1);
    step(1'b0, '0, 1'b1, "rx_pop");
    check("rx_pop.pndng_const", 32'(pndng), 32'd0);
    check("rx_pop.count_const", 32'(count), 32'd0);

    // address filter
    step(1'b1, 16'h0111, 1'b0, "filt");
    step(1'b1, 16'h0399, 1'b0, "filt");
    idle(2, "filt");
    check("filt.drop_const",  32'(drop_cnt), 32'd2);
    check("filt.rx_const",    32'(rx_cnt),   32'd1);
    check("filt.pndng_const", 32'(pndng),    32'd0);

    // overflow and wrap
    for (int i = 0; i < 9; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, "ovf");
    idle(1, "ovf");
    check("ovf.full_const",  32'(full),    32'd1);
    check("ovf.count_const", 32'(count),   32'd8);
    check("ovf.ovf_const",   32'(ovf_cnt), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("ovf.order", 32'(d_pop), 32'h0200 + 32'(i));
      step(1'b0, '0, 1'b1, "drain");
    end
    step(1'b1, 16'h02AA, 1'b0, "wrap");
    idle(1, "wrap");
    check("wrap.dpop_const", 32'(d_pop), 32'h02AA);
    step(1'b0, '0, 1'b1, "wrap");

    // simultaneous pop and write at full
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0210 + 16'(i), 1'b0, "fill");
    idle(1, "fill");
    step(1'b1, 16'h02BB, 1'b0, "simul");
    step(1'b0, '0, 1'b1, "simul");
    check("simul.ovf_const",   32'(ovf_cnt), 32'd1);
    check("simul.count_const", 32'(count),   32'd8);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, "simul_drain");
    check("simul.last_const", 32'(d_pop), 32'h02BB);
    step(1'b0, '0, 1'b1, "simul_drain");

    // broadcast
    base_rx = int'(rx_cnt); base_drop = int'(drop_cnt);
    step(1'b1, 16'hFF55, 1'b0, "bcast");
    idle(1, "bcast");
`ifdef BUS_RX_BROADCAST_EN
    check("bcast.rx",   32'(rx_cnt), 32'(base_rx + 1));
    check("bcast.dpop", 32'(d_pop),  32'hFF55);
`else
    check("bcast.drop",  32'(drop_cnt), 32'(base_drop + 1));
    check("bcast.pndng", 32'(pndng),    32'd0);
`endif
    step(1'b0, '0, 1'b1, "bcast");

    // reset mid-stream with count=3 and a word in flight
    for (int i = 0; i < 4; i++) step(1'b1, 16'h0220 + 16'(i), 1'b0, "mid");
    check("mid.count_const", 32'(count), 32'd3);
    push = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    check("async_rst.dpop_const", 32'(d_pop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h02CC, 1'b0, "post_rst");
    idle(2, "post_rst");
    check("post_rst.dpop_const",  32'(d_pop), 32'h02CC);
    check("post_rst.count_const", 32'(count), 32'd1);
    step(1'b0, '0, 1'b1, "post_rst");
    check("post_rst.empty_const", 32'(pndng), 32'd0);

    // randomized traffic in phases of differing drain rate
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       pop_pct = 10;
        1:       pop_pct = 50;
        2:       pop_pct = 90;
        default: pop_pct = 30;
      endcase
      for (int c = 0; c < 500; c++) begin
        p  = ($urandom_range(0, 99) < 80);
        pp = ($urandom_range(0, 99) < pop_pct);
        case ($urandom_range(0, 7))
          0, 1, 2: w = {8'(ID), 8'($urandom)};
          3:       w = {8'hFF, 8'($urandom)};
          4:       w = {8'($urandom_range(0, DEV - 1)), 8'($urandom)};
          default: w = 16'($urandom);
        endcase
        step(p, w, pp, "rand");
      end
    end
    check("rand.drop_sat", 32'(drop_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
